// File: rtl/rv32i_pkg.sv
// rv32i_pkg: shared decoder control bundle, sequencer states and trap cause codes
package rv32i_pkg;
  typedef struct packed {
    logic reg_write;
    logic mem_read;
    logic mem_write;
    logic branch;
    logic jump;
  } ctrl_signals_t;
  typedef enum logic [2:0] {S_FETCH, S_DECODE, S_EXECUTE, S_MEM, S_WB, S_HALT, S_TRAP} ctrl_state_e;
  localparam logic [1:0] CAUSE_NONE    = 2'b00;
  localparam logic [1:0] CAUSE_ILLEGAL = 2'b01;
  localparam logic [1:0] CAUSE_IMEM_TO = 2'b10;
  localparam logic [1:0] CAUSE_DMEM_TO = 2'b11;
endpackage

// File: rtl/rv32i_ctrl_fsm_if.sv
// rv32i_ctrl_fsm_if: fetch and data bus handshakes between the sequencer and memory
interface rv32i_ctrl_fsm_if;
  logic imem_req_valid;
  logic imem_req_ready;
  logic imem_rsp_valid;
  logic dmem_req_valid;
  logic dmem_req_ready;
  logic dmem_rsp_valid;
  modport master (
    output imem_req_valid, dmem_req_valid,
    input  imem_req_ready, imem_rsp_valid, dmem_req_ready, dmem_rsp_valid
  );
  modport slave (
    input  imem_req_valid, dmem_req_valid,
    output imem_req_ready, imem_rsp_valid, dmem_req_ready, dmem_rsp_valid
  );
endinterface

// File: rtl/rv32i_bus_timeout.sv
// rv32i_bus_timeout: wait-cycle counter that flags expiry on the TIMEOUT-th enabled cycle
module rv32i_bus_timeout #(
  parameter int TIMEOUT = 64
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic expired
);
  localparam int W = TIMEOUT > 1 ? $clog2(TIMEOUT) : 1;
  logic [W-1:0] cnt;
  always_ff @(posedge clk)
    if (rst || clr) cnt <= '0;
    else if (en && !expired) cnt <= cnt + W'(1);
  // TIMEOUT of zero never expires
  assign expired = (TIMEOUT != 0) && en && (cnt == W'(TIMEOUT - 1));
endmodule

// File: rtl/rv32i_ctrl_fsm.sv
// rv32i_ctrl_fsm: multi-cycle FETCH/DECODE/EXECUTE/MEM/WB sequencer with halt, trap and bus timeout
module rv32i_ctrl_fsm
  import rv32i_pkg::*;
#(
  parameter int BUS_TIMEOUT   = 64,
  parameter int INSTRET_WIDTH = 32
) (
  input  logic                     clk,
  input  logic                     rst,
  rv32i_ctrl_fsm_if.master         bus,
  input  ctrl_signals_t            ctrl,
  input  logic                     illegal_instr,
  input  logic                     is_ebreak,
  input  logic                     branch_taken,
  input  logic                     halt_req,
  input  logic                     resume_req,
  output logic                     ir_we,
  output logic                     pc_we,
  output logic                     pc_sel_target,
  output logic                     rf_we,
  output ctrl_state_e              state,
  output logic                     halted,
  output logic                     trap,
  output logic [1:0]               trap_cause,
  output logic [INSTRET_WIDTH-1:0] instret
);
  ctrl_state_e nxt;
  logic [1:0] cause_nxt;
  logic first, acc, take_target, expired, waiting, ready, rsp;
  rv32i_bus_timeout #(.TIMEOUT(BUS_TIMEOUT)) u_timeout (
    .clk, .rst, .clr(nxt != state), .en(waiting), .expired
  );
  assign halted = state == S_HALT || state == S_TRAP;
  assign trap   = state == S_TRAP;
  always_comb begin
    nxt = state;
    cause_nxt = trap_cause;
    ir_we = 1'b0;
    pc_we = 1'b0;
    rf_we = 1'b0;
    pc_sel_target = 1'b0;
    bus.imem_req_valid = 1'b0;
    bus.dmem_req_valid = 1'b0;
    waiting = state == S_FETCH || state == S_MEM;
    ready = state == S_MEM ? bus.dmem_req_ready : bus.imem_req_ready;
    rsp = state == S_MEM ? bus.dmem_rsp_valid : bus.imem_rsp_valid;
    case (state)
      S_FETCH:
        if (first && halt_req) nxt = S_HALT;
        else begin
          bus.imem_req_valid = !acc;
          // a response only counts once the request has been (or is being) accepted
          if ((acc || ready) && rsp) begin
            ir_we = 1'b1;
            nxt = S_DECODE;
          end else if (expired) begin
            nxt = S_TRAP;
            cause_nxt = CAUSE_IMEM_TO;
          end
        end
      S_DECODE: begin
        nxt = illegal_instr ? S_TRAP : is_ebreak ? S_HALT : S_EXECUTE;
        cause_nxt = illegal_instr ? CAUSE_ILLEGAL : trap_cause;
      end
      S_EXECUTE: nxt = (ctrl.mem_read || ctrl.mem_write) ? S_MEM : S_WB;
      S_MEM: begin
        bus.dmem_req_valid = !acc;
        if ((acc || ready) && rsp) nxt = S_WB;
        else if (expired) begin
          nxt = S_TRAP;
          cause_nxt = CAUSE_DMEM_TO;
        end
      end
      S_WB: begin
        rf_we = ctrl.reg_write;
        pc_we = 1'b1;
        pc_sel_target = take_target;
        nxt = S_FETCH;
      end
      S_HALT: nxt = resume_req && !halt_req ? S_FETCH : S_HALT;
      S_TRAP: nxt = S_TRAP;
      default: nxt = S_FETCH;
    endcase
  end
  always_ff @(posedge clk)
    if (rst) begin
      state <= S_FETCH;
      first <= 1'b1;
      acc <= 1'b0;
      take_target <= 1'b0;
      trap_cause <= CAUSE_NONE;
      instret <= '0;
    end else begin
      state <= nxt;
      first <= nxt != state;
      acc <= nxt == state && (acc || ((bus.imem_req_valid || bus.dmem_req_valid) && ready));
      if (state == S_EXECUTE) take_target <= ctrl.jump || (ctrl.branch && branch_taken);
      trap_cause <= cause_nxt;
      if (pc_we) instret <= instret + INSTRET_WIDTH'(1);
    end
endmodule

// File: tb/tb_rv32i_ctrl_fsm.sv
// tb_rv32i_ctrl_fsm: table-driven instruction vectors plus halt/trap/timeout sequences
module tb_rv32i_ctrl_fsm;
  import rv32i_pkg::*;
  logic clk = 1'b0, rst = 1'b1;
  always #5 clk = ~clk;
  rv32i_ctrl_fsm_if bus();
  ctrl_signals_t ctrl;
  logic illegal_instr, is_ebreak, branch_taken, halt_req, resume_req;
  logic ir_we, pc_we, pc_sel_target, rf_we, halted, trap;
  ctrl_state_e state;
  logic [1:0] trap_cause;
  logic [31:0] instret;
  rv32i_ctrl_fsm #(.BUS_TIMEOUT(8), .INSTRET_WIDTH(32)) dut (
    .clk(clk), .rst(rst), .bus(bus), .ctrl(ctrl), .illegal_instr(illegal_instr),
    .is_ebreak(is_ebreak), .branch_taken(branch_taken), .halt_req(halt_req),
    .resume_req(resume_req), .ir_we(ir_we), .pc_we(pc_we), .pc_sel_target(pc_sel_target),
    .rf_we(rf_we), .state(state), .halted(halted), .trap(trap), .trap_cause(trap_cause),
    .instret(instret)
  );
  typedef struct {
    string name;
    ctrl_signals_t c;
    bit taken;
    int idl, ddl;
    bit same;
    int e_cyc, e_ir, e_rf;
    bit e_sel;
    int e_dv, e_iv;
  } vec_t;
  int checks = 0, errors = 0;
  int i_delay, d_delay, iw, dw;
  bit i_stuck, d_stuck, d_same, i_pend, d_pend, iacc, dacc;
  int cyc, ir_cyc, rf_n, rf_cyc, pc_n, dv_n, iv_n, excl;
  bit sel, s_halted;
  ctrl_state_e s_state;
  vec_t vecs[8];

  function automatic vec_t mk(string n, logic [4:0] c, bit tk, int idl, int ddl, bit sm,
                              int ec, int eir, int erf, bit es, int edv, int eiv);
    vec_t v;
    v.name = n; v.c = c; v.taken = tk; v.idl = idl; v.ddl = ddl; v.same = sm;
    v.e_cyc = ec; v.e_ir = eir; v.e_rf = erf; v.e_sel = es; v.e_dv = edv; v.e_iv = eiv;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic clear_stats();
    cyc = 0; ir_cyc = 0; rf_n = 0; rf_cyc = 0; pc_n = 0; dv_n = 0; iv_n = 0; sel = 1'b0;
    s_halted = 1'b0;
  endtask

  // one clock: memory model drives ready/rsp, outputs are sampled mid-cycle
  task automatic tick();
    #3;
    bus.imem_req_ready = bus.imem_req_valid && !i_stuck && iw >= i_delay;
    bus.imem_rsp_valid = i_pend;
    bus.dmem_req_ready = bus.dmem_req_valid && !d_stuck && dw >= d_delay;
    bus.dmem_rsp_valid = d_pend || (d_same && bus.dmem_req_ready);
    #2;
    cyc++;
    if (bus.imem_req_valid) iv_n++;
    if (bus.dmem_req_valid) dv_n++;
    if (ir_we) ir_cyc = cyc;
    if (rf_we) begin rf_n++; rf_cyc = cyc; end
    if (pc_we) begin pc_n++; sel = pc_sel_target; end
    if (ir_we && (rf_we || pc_we)) excl++;
    s_halted = halted;
    s_state = state;
    iacc = bus.imem_req_valid && bus.imem_req_ready;
    dacc = bus.dmem_req_valid && bus.dmem_req_ready;
    if (bus.imem_req_valid && !iacc) iw++;
    if (bus.dmem_req_valid && !dacc) dw++;
    @(posedge clk);
    #1;
    if (iacc) iw = 0;
    if (dacc) dw = 0;
    i_pend = iacc;
    d_pend = dacc && !d_same;
  endtask

  task automatic run_instr(input int budget);
    clear_stats();
    while (pc_n == 0 && !s_halted && cyc < budget) tick();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    bus.imem_req_ready = 1'b0; bus.imem_rsp_valid = 1'b0;
    bus.dmem_req_ready = 1'b0; bus.dmem_rsp_valid = 1'b0;
    i_pend = 1'b0; d_pend = 1'b0; iw = 0; dw = 0;
    repeat (2) begin @(posedge clk); #1; end
    rst = 1'b0;
  endtask

  initial begin
    ctrl = '0; illegal_instr = 1'b0; is_ebreak = 1'b0; branch_taken = 1'b0;
    halt_req = 1'b0; resume_req = 1'b0;
    i_delay = 0; d_delay = 0; i_stuck = 1'b0; d_stuck = 1'b0; d_same = 1'b0; excl = 0;
    //            name        {rw,mr,mw,br,j} tk idl ddl same cyc ir rf sel dv iv
    vecs[0] = mk("addi",      5'b10000, 0, 0, 0, 0,  5, 2, 1, 0, 0, 1);
    vecs[1] = mk("lw_wait3",  5'b11000, 0, 0, 3, 0, 10, 2, 1, 0, 4, 1);
    vecs[2] = mk("sw",        5'b00100, 0, 0, 0, 0,  7, 2, 0, 0, 1, 1);
    vecs[3] = mk("beq_taken", 5'b00010, 1, 0, 0, 0,  5, 2, 0, 1, 0, 1);
    vecs[4] = mk("bne_not",   5'b00010, 0, 0, 0, 0,  5, 2, 0, 0, 0, 1);
    vecs[5] = mk("jal",       5'b10001, 0, 0, 0, 0,  5, 2, 1, 1, 0, 1);
    vecs[6] = mk("addi_iw2",  5'b10000, 0, 2, 0, 0,  7, 4, 1, 0, 0, 3);
    vecs[7] = mk("lw_same",   5'b11000, 0, 0, 1, 1,  7, 2, 1, 0, 2, 1);
    do_reset();
    chk("reset_state", 32'(state), 32'(S_FETCH));
    chk("reset_halted", 32'(halted), 0);
    chk("reset_trap", 32'(trap), 0);
    chk("reset_cause", 32'(trap_cause), 0);
    chk("reset_instret", instret, 0);
    chk("reset_ir_we", 32'(ir_we), 0);
    foreach (vecs[k]) begin
      ctrl = vecs[k].c; branch_taken = vecs[k].taken;
      i_delay = vecs[k].idl; d_delay = vecs[k].ddl; d_same = vecs[k].same;
      run_instr(40);
      chk({vecs[k].name, "_cycles"}, cyc, vecs[k].e_cyc);
      chk({vecs[k].name, "_ir_cycle"}, ir_cyc, vecs[k].e_ir);
      chk({vecs[k].name, "_rf_count"}, rf_n, vecs[k].e_rf);
      if (vecs[k].e_rf != 0) chk({vecs[k].name, "_rf_cycle"}, rf_cyc, vecs[k].e_cyc);
      chk({vecs[k].name, "_pc_we"}, pc_n, 1);
      chk({vecs[k].name, "_pc_sel"}, 32'(sel), 32'(vecs[k].e_sel));
      chk({vecs[k].name, "_dmem_valid"}, dv_n, vecs[k].e_dv);
      chk({vecs[k].name, "_imem_valid"}, iv_n, vecs[k].e_iv);
      chk({vecs[k].name, "_instret"}, instret, k + 1);
    end
    i_delay = 0; d_delay = 0; d_same = 1'b0; branch_taken = 1'b0;
    // EBREAK halts without advancing the PC, resume restarts fetch
    ctrl = '0; is_ebreak = 1'b1;
    run_instr(20);
    chk("ebreak_halted", 32'(s_halted), 1);
    chk("ebreak_cycles", cyc, 4);
    chk("ebreak_pc_we", pc_n, 0);
    is_ebreak = 1'b0;
    clear_stats();
    repeat (3) tick();
    chk("halt_no_fetch", iv_n, 0);
    chk("halt_no_pc_we", pc_n, 0);
    chk("halt_state", 32'(state), 32'(S_HALT));
    resume_req = 1'b1; tick(); resume_req = 1'b0;
    ctrl = 5'b10000;
    run_instr(20);
    chk("resume_cycles", cyc, 5);
    chk("resume_instret", instret, 9);
    // halt request seen on fetch entry, resume ignored while still requested
    halt_req = 1'b1;
    clear_stats();
    tick();
    chk("haltreq_no_req", iv_n, 0);
    chk("haltreq_state", 32'(state), 32'(S_HALT));
    resume_req = 1'b1; tick(); resume_req = 1'b0;
    tick();
    chk("resume_blocked", 32'(state), 32'(S_HALT));
    halt_req = 1'b0;
    resume_req = 1'b1; tick(); resume_req = 1'b0;
    chk("resume_fetch", 32'(state), 32'(S_FETCH));
    run_instr(20);
    chk("haltreq_instret", instret, 10);
    // illegal instruction traps permanently
    illegal_instr = 1'b1;
    run_instr(20);
    illegal_instr = 1'b0;
    chk("illegal_trap", 32'(trap), 1);
    chk("illegal_cause", 32'(trap_cause), 1);
    chk("illegal_halted", 32'(halted), 1);
    clear_stats();
    repeat (6) tick();
    chk("trap_no_fetch", iv_n, 0);
    chk("trap_no_pc_we", pc_n, 0);
    chk("trap_state", 32'(state), 32'(S_TRAP));
    do_reset();
    chk("rst_after_trap", 32'(trap), 0);
    chk("rst_after_trap_state", 32'(state), 32'(S_FETCH));
    // fetch never accepted: trap on the eighth wait cycle
    i_stuck = 1'b1;
    clear_stats();
    repeat (8) tick();
    chk("imem_to_wait_state", 32'(s_state), 32'(S_FETCH));
    chk("imem_to_valid_cycles", iv_n, 8);
    tick();
    chk("imem_to_state", 32'(s_state), 32'(S_TRAP));
    chk("imem_to_cause", 32'(trap_cause), 2);
    i_stuck = 1'b0;
    do_reset();
    chk("imem_to_reset_trap", 32'(trap), 0);
    chk("imem_to_reset_state", 32'(state), 32'(S_FETCH));
    // data request never accepted
    ctrl = 5'b11000; d_stuck = 1'b1;
    run_instr(30);
    chk("dmem_to_cause", 32'(trap_cause), 3);
    chk("dmem_to_valid_cycles", dv_n, 8);
    chk("dmem_to_rf", rf_n, 0);
    d_stuck = 1'b0;
    do_reset();
    chk("strobe_exclusive", excl, 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
